wb_spi_master: RTL and testbench
================================

// Module: wb_spi_master
// PURPOSE
//  Wishbone-slave SPI master, successor to the fixed 8-bit single-target SPI core. Adds programmable word
//  length, CPOL/CPHA modes, clock divider, NCS chip selects, TX/RX FIFOs and a completion interrupt.
//  Sits on the LM32 SoC Wishbone bus as a peripheral; the CPU streams words without polling per bit.
// PARAMETERS
//  NCS        4   number of chip-select outputs (1..8)
//  DIV_W      16  width of clock-divider register
//  FIFO_DEPTH 8   entries per TX and RX FIFO (power of 2, >=2); entries are 32 bits
// PORTS
//  clk       in  1      system clock
//  reset     in  1      asynchronous, active-low reset
//  wb_adr_i  in  32     word address, decoded on [4:2]
//  wb_dat_i  in  32     write data
//  wb_dat_o  out 32     read data, valid with wb_ack_o
//  wb_sel_i  in  4      byte selects (ignored; full-word access)
//  wb_cyc_i  in  1      bus cycle
//  wb_stb_i  in  1      strobe
//  wb_we_i   in  1      1=write
//  wb_ack_o  out 1      single-cycle acknowledge
//  sck       out 1      SPI clock
//  mosi      out 1      SPI data out
//  miso      in  1      SPI data in (registered once at sample edge)
//  cs_n      out NCS    active-low chip selects
//  irq       out 1      level interrupt, = IRQ_PEND & IRQ_EN
// BEHAVIOUR
//  Reset (async, reset=0): sck=0, mosi=0, cs_n=all 1, irq=0, wb_ack_o=0, wb_dat_o=0, all regs 0, FIFOs empty.
//  Bus: access when cyc&stb&~ack; ack registered, asserted exactly 1 cycle later for 1 cycle; every access acked.
//  Regs [4:2]: 0 CTRL rw: [0]EN [1]CPOL [2]CPHA [3]LSB_FIRST [4]CS_AUTO [5]IRQ_EN [10:6]LEN-1 (1..32 bits)
//   1 DIV rw: sck half-period = DIV+1 clk cycles   2 CS rw: [NCS-1:0] target select, active-high
//   3 STATUS: [0]BUSY [1]TX_FULL [2]TX_EMPTY [3]RX_FULL [4]RX_EMPTY [5]RX_OVR [6]IRQ_PEND; W1C on [6:5]
//   4 TXDATA wo: push; write when TX_FULL dropped   5 RXDATA ro: pop; read when RX_EMPTY returns 0
//  Unmapped reads return 0; unmapped writes ignored. TX word right-aligned in [LEN-1:0].
//  FSM IDLE->SETUP->SHIFT->HOLD->(SETUP|IDLE). IDLE->SETUP when EN=1 and TX FIFO nonempty: pop word,
//   snapshot CPOL/CPHA/LSB_FIRST/LEN/DIV/CS (later reg writes affect next word only).
//  SETUP: cs_n[i]=~CS[i], sck=CPOL, 1 half-period; CPHA=0 drives first bit on mosi here.
//  SHIFT: 2*LEN half-periods. CPHA=0: sample on leading edge, drive next bit on trailing. CPHA=1: drive on
//   leading, sample on trailing. Bit order MSB-first unless LSB_FIRST. sck returns to CPOL after last edge.
//  HOLD: 1 half-period; push RX word (zero-extended) on entry; set IRQ_PEND when TX FIFO empty at word end.
//   Exit: TX nonempty & CS_AUTO=1 -> SETUP keeping cs_n low (back-to-back); TX nonempty & CS_AUTO=0 -> cs_n
//   high 1 half-period then SETUP; TX empty -> cs_n high, IDLE.
//  RX full at push: word discarded, RX_OVR set (sticky). Simultaneous push+pop same cycle on a full FIFO
//   is legal for TX and RX; counts unchanged. FIFO pointers wrap modulo FIFO_DEPTH.
//  BUSY=1 in any state but IDLE. EN cleared mid-word: abort next clk, cs_n all 1, sck=CPOL, partial RX
//   discarded, TX FIFO kept. Async reset mid-transfer: outputs to reset values immediately.
//  DIV=0: sck toggles every clk (sck=clk/2). mosi held at last bit while IDLE.
// TESTING
//  1 Reset: hold reset=0 5 clk -> cs_n=4'hF, sck=0, STATUS=32'h14; any read acked after 1 cycle.
//  2 Mode0 8-bit: CTRL=0x1C1 (EN,LEN=8), DIV=1, CS=1, TX 0xA5, miso loopback -> 8 sck pulses of 4 clk, mosi
//    1010_0101, cs_n=4'hE only during word, RXDATA=0xA5, IRQ_PEND=1.
//  3 All modes: CPOL/CPHA 0..3, LEN=32, TX 0xDEADBEEF, slave model -> sck idle=CPOL, RX 0xDEADBEEF each mode.
//  4 Burst: CS_AUTO=1, push 3 words LEN=16 -> cs_n low continuously over 48 bits; CS_AUTO=0 -> 3 gaps.
//  5 Overrun: 9 words with no RX reads (DEPTH 8) -> 9th dropped, RX_OVR=1; W1C 0x20 clears it.
//  6 Abort: clear EN at bit 4 of 8 -> cs_n=F next clk, RX_EMPTY=1, remaining TX words intact.

Source files
------------

// File: rtl/wb_spi_master.sv
// Wishbone-slave SPI master with programmable word length, CPOL/CPHA, clock divider,
// chip selects, 32-bit TX/RX FIFOs and a completion interrupt.

module wb_spi_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [31:0] data_i,
  input  logic        pop_i,
  output logic [31:0] data_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push_s, do_pop_s;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
  assign empty_o   = (cnt_q == {(AW+1){1'b0}});
  assign full_o    = (cnt_q == FULL_CNT);
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign data_o    = mem_q[rptr_q];

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wptr_q] <= data_i;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= {AW{1'b0}};
      rptr_q <= {AW{1'b0}};
      cnt_q  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wptr_q <= wptr_q + 1'b1;
      if (do_pop_s)  rptr_q <= rptr_q + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module wb_spi_master #(
  parameter int NCS        = 4,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    wb_adr_i,
  input  logic [31:0]    wb_dat_i,
  output logic [31:0]    wb_dat_o,
  input  logic [3:0]     wb_sel_i,
  input  logic           wb_cyc_i,
  input  logic           wb_stb_i,
  input  logic           wb_we_i,
  output logic           wb_ack_o,
  output logic           sck,
  output logic           mosi,
  input  logic           miso,
  output logic [NCS-1:0] cs_n,
  output logic           irq
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e          state_q;
  logic [10:0]     ctrl_q;
  logic [DIV_W-1:0] div_q, div_s_q, hcnt_q;
  logic [NCS-1:0]  cs_q, cs_n_q;
  logic            rx_ovr_q, irq_pend_q, irq_q, ack_q;
  logic [31:0]     dat_q, tx_sh_q, rx_sh_q;
  logic            cpol_q, cpha_q, lsb_q, sck_q, mosi_q, rx_push_q;
  logic [4:0]      len1_q;
  logic [5:0]      edge_q;

  logic            req_s, wr_s, rd_s, tx_push_s, rx_pop_s, w1c_s, start_s, tick_s, busy_s;
  logic            last_edge_s, rx_ovr_set_s;
  logic [2:0]      addr_s;
  logic [31:0]     rdata_s, tx_dout_s, rx_dout_s, tx_aligned_s, tx_next_s, rx_word_s;
  logic            tx_full_s, tx_empty_s, rx_full_s, rx_empty_s, tx_lead_s;
  logic            unused_s;

  assign unused_s = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0]};

  assign req_s     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_s      = req_s & wb_we_i;
  assign rd_s      = req_s & ~wb_we_i;
  assign addr_s    = wb_adr_i[4:2];
  assign tx_push_s = wr_s & (addr_s == 3'd4);
  assign rx_pop_s  = rd_s & (addr_s == 3'd5);
  assign w1c_s     = wr_s & (addr_s == 3'd3);

  assign busy_s      = (state_q != S_IDLE);
  assign tick_s      = (hcnt_q == {DIV_W{1'b0}});
  assign last_edge_s = (edge_q == {len1_q, 1'b1});

  // Outgoing word is pre-shifted so the next bit always sits at bit 31 (MSB-first) or bit 0
  assign tx_aligned_s = ctrl_q[3] ? tx_dout_s : (tx_dout_s << (5'd31 - ctrl_q[10:6]));
  assign tx_lead_s    = ctrl_q[3] ? tx_aligned_s[0] : tx_aligned_s[31];
  assign tx_next_s    = ctrl_q[3] ? (tx_aligned_s >> 5'd1) : (tx_aligned_s << 5'd1);
  assign rx_word_s    = lsb_q ? (rx_sh_q >> (5'd31 - len1_q)) : rx_sh_q;
  assign rx_ovr_set_s = rx_push_q & rx_full_s & ~rx_pop_s;

  wb_spi_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(reset), .push_i(tx_push_s), .data_i(wb_dat_i), .pop_i(start_s),
    .data_o(tx_dout_s), .full_o(tx_full_s), .empty_o(tx_empty_s)
  );

  wb_spi_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(reset), .push_i(rx_push_q), .data_i(rx_word_s), .pop_i(rx_pop_s),
    .data_o(rx_dout_s), .full_o(rx_full_s), .empty_o(rx_empty_s)
  );

  // Word start: from idle, back-to-back from hold, or after the chip-select gap
  always_comb begin
    start_s = 1'b0;
    case (state_q)
      S_IDLE:  start_s = ctrl_q[0] & ~tx_empty_s;
      S_HOLD:  start_s = ctrl_q[0] & tick_s & ~tx_empty_s & ctrl_q[4];
      S_GAP:   start_s = ctrl_q[0] & tick_s & ~tx_empty_s;
      default: start_s = 1'b0;
    endcase
  end

  // Register read mux
  always_comb begin
    rdata_s = 32'h0;
    case (addr_s)
      3'd0:    rdata_s[10:0]      = ctrl_q;
      3'd1:    rdata_s[DIV_W-1:0] = div_q;
      3'd2:    rdata_s[NCS-1:0]   = cs_q;
      3'd3:    rdata_s[6:0]       = {irq_pend_q, rx_ovr_q, rx_empty_s, rx_full_s,
                                     tx_empty_s, tx_full_s, busy_s};
      3'd5:    rdata_s            = rx_empty_s ? 32'h0 : rx_dout_s;
      default: rdata_s            = 32'h0;
    endcase
  end

  // Bus response, control registers and sticky status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      ctrl_q     <= 11'h0;
      div_q      <= {DIV_W{1'b0}};
      cs_q       <= {NCS{1'b0}};
      rx_ovr_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ack_q <= req_s;
      dat_q <= rd_s ? rdata_s : 32'h0;
      if (wr_s && addr_s == 3'd0) ctrl_q <= wb_dat_i[10:0];
      if (wr_s && addr_s == 3'd1) div_q  <= wb_dat_i[DIV_W-1:0];
      if (wr_s && addr_s == 3'd2) cs_q   <= wb_dat_i[NCS-1:0];
      if (rx_ovr_set_s)                rx_ovr_q <= 1'b1;
      else if (w1c_s && wb_dat_i[5])   rx_ovr_q <= 1'b0;
      if (rx_push_q && tx_empty_s)     irq_pend_q <= 1'b1;
      else if (w1c_s && wb_dat_i[6])   irq_pend_q <= 1'b0;
      irq_q <= irq_pend_q & ctrl_q[5];
    end
  end

  // Transfer sequencer: half-period timing, shift registers and SPI pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      hcnt_q    <= {DIV_W{1'b0}};
      div_s_q   <= {DIV_W{1'b0}};
      edge_q    <= 6'd0;
      tx_sh_q   <= 32'h0;
      rx_sh_q   <= 32'h0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      len1_q    <= 5'd0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= {NCS{1'b1}};
      rx_push_q <= 1'b0;
    end else if (busy_s && !ctrl_q[0]) begin
      state_q   <= S_IDLE;
      sck_q     <= cpol_q;
      cs_n_q    <= {NCS{1'b1}};
      rx_push_q <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      hcnt_q    <= tick_s ? div_s_q : (hcnt_q - 1'b1);
      if (start_s) begin
        state_q <= S_SETUP;
        cpol_q  <= ctrl_q[1];
        cpha_q  <= ctrl_q[2];
        lsb_q   <= ctrl_q[3];
        len1_q  <= ctrl_q[10:6];
        div_s_q <= div_q;
        hcnt_q  <= div_q;
        edge_q  <= 6'd0;
        rx_sh_q <= 32'h0;
        sck_q   <= ctrl_q[1];
        cs_n_q  <= ~cs_q;
        if (!ctrl_q[2]) begin
          mosi_q  <= tx_lead_s;
          tx_sh_q <= tx_next_s;
        end else begin
          tx_sh_q <= tx_aligned_s;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            sck_q  <= ctrl_q[1];
            cs_n_q <= {NCS{1'b1}};
          end
          S_SETUP: if (tick_s) state_q <= S_SHIFT;
          S_SHIFT: if (tick_s) begin
            sck_q  <= ~sck_q;
            edge_q <= edge_q + 1'b1;
            // Even edges lead; CPHA selects whether the leading or trailing edge samples
            if (edge_q[0] == cpha_q) begin
              rx_sh_q <= lsb_q ? {miso, rx_sh_q[31:1]} : {rx_sh_q[30:0], miso};
            end else if (!last_edge_s) begin
              mosi_q  <= lsb_q ? tx_sh_q[0] : tx_sh_q[31];
              tx_sh_q <= lsb_q ? (tx_sh_q >> 5'd1) : (tx_sh_q << 5'd1);
            end
            if (last_edge_s) begin
              state_q   <= S_HOLD;
              rx_push_q <= 1'b1;
            end
          end
          S_HOLD: if (tick_s) begin
            cs_n_q  <= {NCS{1'b1}};
            state_q <= tx_empty_s ? S_IDLE : S_GAP;
          end
          S_GAP: if (tick_s) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_wb_spi_master.sv
// Directed self-checking bench for wb_spi_master: loopback and slave-model transfers.

module tb_wb_spi_master;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] wb_adr = 32'h0, wb_dat_w = 32'h0, wb_dat_r;
  logic [3:0]  wb_sel = 4'hF;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, ack;
  logic        sck, mosi, miso, irq;
  logic [3:0]  cs_n;

  int tests_run = 0;
  int tests_failed = 0;

  logic        loop_en = 1'b1;
  logic        slave_miso = 1'b0;
  logic        s_cpol = 1'b0, s_cpha = 1'b0;
  logic [31:0] s_tx = 32'h0, s_sh = 32'h0, s_rx = 32'h0;

  int          rise_cnt = 0, cs_rise = 0;
  logic [31:0] mon_mosi = 32'h0;
  logic [3:0]  mon_cs = 4'h0;
  time         last_rise = 0, per = 0;

  assign miso = loop_en ? mosi : slave_miso;

  wb_spi_master #(.NCS(4), .DIV_W(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
    .wb_sel_i(wb_sel), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_ack_o(ack),
    .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge sck) begin
    rise_cnt  = rise_cnt + 1;
    mon_mosi  = {mon_mosi[30:0], mosi};
    mon_cs    = cs_n;
    per       = $time - last_rise;
    last_rise = $time;
  end

  always @(posedge cs_n[0]) cs_rise = cs_rise + 1;

  // MSB-first SPI slave used by the all-modes test
  always @(negedge cs_n[0]) begin
    s_sh = s_tx;
    if (!s_cpha) slave_miso = s_sh[31];
  end

  always @(sck) begin
    if (!cs_n[0]) begin
      if ((sck != s_cpol) == !s_cpha) s_rx = {s_rx[30:0], mosi};
      else if (!s_cpha) begin s_sh = s_sh << 1; slave_miso = s_sh[31]; end
      else begin slave_miso = s_sh[31]; s_sh = s_sh << 1; end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_adr = {27'd0, a, 2'b00}; wb_dat_w = d; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d, output logic ak);
    @(negedge clk);
    wb_adr = {27'd0, a, 2'b00}; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    ak = ack; d = wb_dat_r;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    logic        ak;
    bit          done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      wb_read(3'd3, st, ak);
      if (!st[0]) done = 1'b1;
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s_idle: BUSY stayed 1, required 0 within budget", tag);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        ak;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++; if (cs_n !== 4'hF) begin tests_failed++; $display("FAIL reset_cs_n: got %h required F", cs_n); end
    tests_run++; if (sck !== 1'b0 || mosi !== 1'b0) begin tests_failed++; $display("FAIL reset_sck_mosi: got %b%b required 00", sck, mosi); end
    tests_run++; if (irq !== 1'b0 || ack !== 1'b0 || wb_dat_r !== 32'h0) begin tests_failed++; $display("FAIL reset_bus: irq %b ack %b dat %h required 0 0 0", irq, ack, wb_dat_r); end
    reset = 1'b1;
    wb_read(3'd3, d, ak);
    tests_run++; if (ak !== 1'b1) begin tests_failed++; $display("FAIL reset_ack: got %b required 1", ak); end
    tests_run++; if (d !== 32'h14) begin tests_failed++; $display("FAIL reset_status: got %h required 00000014", d); end
    @(posedge clk); #1;
    tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack_single: got %b required 0", ack); end
  endtask

  task automatic test_mode0();
    logic [31:0] d;
    logic        ak;
    loop_en = 1'b1;
    wb_write(3'd1, 32'd1);
    wb_write(3'd2, 32'd1);
    wb_write(3'd4, 32'hA5);
    rise_cnt = 0; cs_rise = 0; mon_mosi = 32'h0;
    wb_write(3'd0, 32'h1C1);
    wait_idle("mode0");
    tests_run++; if (rise_cnt !== 8) begin tests_failed++; $display("FAIL mode0_pulses: got %0d required 8", rise_cnt); end
    tests_run++; if (per !== 40) begin tests_failed++; $display("FAIL mode0_period: got %0t required 40", per); end
    tests_run++; if (mon_mosi[7:0] !== 8'hA5) begin tests_failed++; $display("FAIL mode0_mosi: got %h required a5", mon_mosi[7:0]); end
    tests_run++; if (mon_cs !== 4'hE || cs_n !== 4'hF || cs_rise !== 1) begin tests_failed++; $display("FAIL mode0_cs: during %h after %h rises %0d required e f 1", mon_cs, cs_n, cs_rise); end
    wb_read(3'd3, d, ak);
    tests_run++; if (d !== 32'h44) begin tests_failed++; $display("FAIL mode0_status: got %h required 00000044", d); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL mode0_irq_masked: got %b required 0", irq); end
    wb_read(3'd5, d, ak);
    tests_run++; if (d !== 32'hA5) begin tests_failed++; $display("FAIL mode0_rx: got %h required 000000a5", d); end
    wb_write(3'd0, 32'h1E1);
    wb_read(3'd0, d, ak);
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL mode0_irq_en: got %b required 1", irq); end
    wb_write(3'd3, 32'h40);
    wb_read(3'd3, d, ak);
    tests_run++; if (irq !== 1'b0 || d !== 32'h14) begin tests_failed++; $display("FAIL mode0_irq_clear: irq %b status %h required 0 00000014", irq, d); end
  endtask

  task automatic test_all_modes();
    logic [31:0] d, c;
    logic        ak;
    loop_en = 1'b0;
    wb_write(3'd1, 32'd0);
    for (int m = 0; m < 4; m++) begin
      c = 32'h7C1; c[1] = m[1]; c[2] = m[0];
      s_cpol = m[1]; s_cpha = m[0]; s_tx = 32'hDEADBEEF; s_rx = 32'h0;
      wb_write(3'd0, c);
      repeat (2) @(posedge clk); #1;
      tests_run++; if (sck !== s_cpol) begin tests_failed++; $display("FAIL modes_idle_sck m%0d: got %b required %b", m, sck, s_cpol); end
      wb_write(3'd4, 32'hDEADBEEF);
      wait_idle("modes");
      wb_read(3'd5, d, ak);
      tests_run++; if (d !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL modes_rx m%0d: got %h required deadbeef", m, d); end
      tests_run++; if (s_rx !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL modes_slave_rx m%0d: got %h required deadbeef", m, s_rx); end
      tests_run++; if (sck !== s_cpol) begin tests_failed++; $display("FAIL modes_end_sck m%0d: got %b required %b", m, sck, s_cpol); end
    end
    wb_write(3'd0, 32'h0);
    loop_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        ak;
    logic [31:0] words [3];
    words[0] = 32'h1234; words[1] = 32'hABCD; words[2] = 32'h0F0F;
    wb_write(3'd1, 32'd1);
    for (int pass = 0; pass < 2; pass++) begin
      wb_write(3'd0, (pass == 0) ? 32'h3D0 : 32'h3C0);
      for (int i = 0; i < 3; i++) wb_write(3'd4, words[i]);
      rise_cnt = 0; cs_rise = 0;
      wb_write(3'd0, (pass == 0) ? 32'h3D1 : 32'h3C1);
      wait_idle("burst");
      tests_run++; if (rise_cnt !== 48) begin tests_failed++; $display("FAIL burst_bits p%0d: got %0d required 48", pass, rise_cnt); end
      tests_run++; if (cs_rise !== ((pass == 0) ? 1 : 3)) begin tests_failed++; $display("FAIL burst_cs_gaps p%0d: got %0d required %0d", pass, cs_rise, (pass == 0) ? 1 : 3); end
      for (int i = 0; i < 3; i++) begin
        wb_read(3'd5, d, ak);
        tests_run++; if (d !== words[i]) begin tests_failed++; $display("FAIL burst_rx p%0d w%0d: got %h required %h", pass, i, d, words[i]); end
      end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic        ak;
    wb_write(3'd3, 32'h60);
    wb_write(3'd1, 32'd0);
    wb_write(3'd0, 32'h1C1);
    for (int i = 1; i <= 9; i++) wb_write(3'd4, i);
    wait_idle("overrun");
    wb_read(3'd3, d, ak);
    tests_run++; if (d !== 32'h6C) begin tests_failed++; $display("FAIL ovr_status: got %h required 0000006c", d); end
    wb_write(3'd3, 32'h20);
    wb_read(3'd3, d, ak);
    tests_run++; if (d !== 32'h4C) begin tests_failed++; $display("FAIL ovr_w1c: got %h required 0000004c", d); end
    for (int i = 1; i <= 8; i++) begin
      wb_read(3'd5, d, ak);
      tests_run++; if (d !== i) begin tests_failed++; $display("FAIL ovr_rx%0d: got %h required %h", i, d, i); end
    end
    wb_read(3'd3, d, ak);
    tests_run++; if (d !== 32'h54) begin tests_failed++; $display("FAIL ovr_drained: got %h required 00000054", d); end
    wb_write(3'd3, 32'h40);
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic        ak;
    wb_write(3'd0, 32'h1C0);
    wb_write(3'd1, 32'd3);
    wb_write(3'd4, 32'h11);
    wb_write(3'd4, 32'h22);
    rise_cnt = 0;
    wb_write(3'd0, 32'h1C1);
    for (int i = 0; i < 400 && rise_cnt < 4; i++) @(posedge clk);
    tests_run++; if (rise_cnt < 4) begin tests_failed++; $display("FAIL abort_start: got %0d edges required 4", rise_cnt); end
    wb_write(3'd0, 32'h1C0);
    @(posedge clk); #1;
    tests_run++; if (cs_n !== 4'hF || sck !== 1'b0) begin tests_failed++; $display("FAIL abort_pins: cs_n %h sck %b required f 0", cs_n, sck); end
    wb_read(3'd3, d, ak);
    tests_run++; if (d !== 32'h10) begin tests_failed++; $display("FAIL abort_status: got %h required 00000010", d); end
    wb_write(3'd0, 32'h1C1);
    wait_idle("abort");
    wb_read(3'd5, d, ak);
    tests_run++; if (d !== 32'h22) begin tests_failed++; $display("FAIL abort_resume_rx: got %h required 00000022", d); end
    wb_write(3'd3, 32'h60);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic        ak;
    wb_write(3'd4, 32'hFF);
    rise_cnt = 0;
    for (int i = 0; i < 400 && rise_cnt < 2; i++) @(posedge clk);
    tests_run++; if (rise_cnt < 2) begin tests_failed++; $display("FAIL arst_start: got %0d edges required 2", rise_cnt); end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    tests_run++; if (cs_n !== 4'hF || sck !== 1'b0 || mosi !== 1'b0) begin tests_failed++; $display("FAIL arst_pins: cs_n %h sck %b mosi %b required f 0 0", cs_n, sck, mosi); end
    @(negedge clk);
    reset = 1'b1;
    wb_read(3'd3, d, ak);
    tests_run++; if (d !== 32'h14) begin tests_failed++; $display("FAIL arst_status: got %h required 00000014", d); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_all_modes();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
